// File: rtl/ising_pkg.sv
// Shared types and helpers for the checkerboard Metropolis sweep controller.
package ising_pkg;
    typedef enum logic [1:0] {IDLE, EVAL, DECIDE, DONE} state_t;
    typedef logic signed [3:0] de_t;

    localparam de_t DE_MAX = 4'sd4;
    localparam de_t DE_MIN = -4'sd4;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } xy_t;

    function automatic xy_t site_xy(input int addr, input int n);
        xy_t r;
        r.y = 16'(addr / n);
        r.x = 16'(addr % n);
        return r;
    endfunction
endpackage

// File: rtl/ising_delta_e.sv
// Flip energy of one site from its spin and four neighbours (bit 1 = +1, bit 0 = -1).
module ising_delta_e
    import ising_pkg::*;
(
    input  logic s_i,
    input  logic l_i,
    input  logic r_i,
    input  logic t_i,
    input  logic b_i,
    output de_t  de_o,
    output logic free_accept_o
);
    logic [2:0] ones;
    de_t        nsum;

    always_comb begin
        ones = 3'(l_i) + 3'(r_i) + 3'(t_i) + 3'(b_i);
        // neighbour sum in +-1 units is 2*ones - 4
        nsum = de_t'({ones, 1'b0}) - DE_MAX;
        de_o = s_i ? nsum : -nsum;
        free_accept_o = (de_o <= 4'sd0);
    end
endmodule

// File: rtl/ising_sweep_ctrl.sv
// Checkerboard Metropolis sweep sequencer over an N x N periodic spin lattice.
//   IDLE   | waiting for start, lattice loads allowed
//   EVAL   | register dE for site (x,y)
//   DECIDE | accept freely or wait for an RNG word, then advance
//   DONE   | one-cycle done pulse
module ising_sweep_ctrl
    import ising_pkg::*;
#(
    parameter int N  = 8,
    parameter int RW = 16,
    parameter int AW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   sweeps,
    input  logic [RW-1:0] thr2,
    input  logic [RW-1:0] thr4,
    input  logic          rnd_valid,
    input  logic [RW-1:0] rnd_data,
    output logic          rnd_ready,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_spin,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_spin,
    output logic          busy,
    output logic          done,
    output logic [31:0]   accept_cnt
);
    localparam int XW = $clog2(N);

    state_t         state_q;
    logic [N*N-1:0] lat_q;
    logic [XW-1:0]  x_q, y_q, x_d, y_d;
    logic [XW-1:0]  x_m, x_p, y_m, y_p;
    logic           par_q, par_d;
    logic [15:0]    sweeps_q, swp_q, swp_d;
    logic           last_site;
    de_t            de_q, de_w;
    logic           free_q, free_w;
    logic           rdy_q, busy_q, done_q;
    logic [31:0]    acc_q;
    logic [AW-1:0]  a_c, a_l, a_r, a_t, a_b;
    logic [RW-1:0]  thr_sel;
    logic           take, flip;

    function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [XW-1:0] y);
        return AW'(int'(y) * N + int'(x));
    endfunction

    always_comb begin
        x_m = (x_q == '0) ? XW'(N-1) : x_q - XW'(1);
        x_p = (x_q == XW'(N-1)) ? '0 : x_q + XW'(1);
        y_m = (y_q == '0) ? XW'(N-1) : y_q - XW'(1);
        y_p = (y_q == XW'(N-1)) ? '0 : y_q + XW'(1);
        a_c = addr_of(x_q, y_q);
        a_l = addr_of(x_m, y_q);
        a_r = addr_of(x_p, y_q);
        a_t = addr_of(x_q, y_m);
        a_b = addr_of(x_q, y_p);
    end

    ising_delta_e u_de (
        .s_i           (lat_q[a_c]),
        .l_i           (lat_q[a_l]),
        .r_i           (lat_q[a_r]),
        .t_i           (lat_q[a_t]),
        .b_i           (lat_q[a_b]),
        .de_o          (de_w),
        .free_accept_o (free_w)
    );

    // Checkerboard walk: rows restart on the column whose colour matches the parity.
    always_comb begin
        x_d       = x_q + XW'(2);
        y_d       = y_q;
        par_d     = par_q;
        swp_d     = swp_q;
        last_site = 1'b0;
        if (int'(x_q) + 2 >= N) begin
            if (y_q == XW'(N-1)) begin
                y_d = '0;
                if (!par_q) begin
                    par_d = 1'b1;
                    x_d   = XW'(1);
                end else begin
                    swp_d     = swp_q + 16'd1;
                    par_d     = 1'b0;
                    x_d       = '0;
                    last_site = (swp_d == sweeps_q);
                end
            end else begin
                y_d = y_q + XW'(1);
                x_d = {{(XW-1){1'b0}}, ~(y_q[0] ^ par_q)};
            end
        end
    end

    always_comb begin
        thr_sel = (de_q == DE_MAX) ? thr4 : thr2;
        take    = free_q | (rdy_q & rnd_valid);
        flip    = free_q | (rdy_q & rnd_valid & (rnd_data < thr_sel));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lat_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            par_q    <= 1'b0;
            sweeps_q <= '0;
            swp_q    <= '0;
            de_q     <= '0;
            free_q   <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wr_en) lat_q[wr_addr] <= wr_spin;
                    if (start) begin
                        if (sweeps == 16'd0) begin
                            done_q <= 1'b1;
                        end else begin
                            sweeps_q <= sweeps;
                            acc_q    <= '0;
                            x_q      <= '0;
                            y_q      <= '0;
                            par_q    <= 1'b0;
                            swp_q    <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= EVAL;
                        end
                    end
                end
                EVAL: begin
                    de_q    <= de_w;
                    free_q  <= free_w;
                    rdy_q   <= ~free_w;
                    state_q <= DECIDE;
                end
                DECIDE: begin
                    if (take) begin
                        rdy_q <= 1'b0;
                        if (flip) begin
                            lat_q[a_c] <= ~lat_q[a_c];
                            if (acc_q != 32'hFFFF_FFFF) acc_q <= acc_q + 32'd1;
                        end
                        x_q   <= x_d;
                        y_q   <= y_d;
                        par_q <= par_d;
                        swp_q <= swp_d;
                        if (last_site) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            state_q <= EVAL;
                        end
                    end
                end
                DONE: begin
                    if (wr_en) lat_q[wr_addr] <= wr_spin;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rnd_ready  = rdy_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign accept_cnt = acc_q;
    assign rd_spin    = lat_q[rd_addr];
endmodule
